// File: rtl/i2s_recv_if.sv
// I2S receiver bus: serial side (lrclk / CBrise / inbit) plus the
// parallel sample handshake and status flags.
// master = stream source and sample consumer, slave = the receiver.
interface i2s_recv_if #(
  parameter int DATA_BITS = 32
);
  logic                 lrclk;
  logic                 CBrise;
  logic                 inbit;
  logic [DATA_BITS-1:0] sample;
  logic                 rcv_rdy;
  logic                 rcv_ack;
  logic                 overrun;
  logic                 frame_err;

  modport master (
    output lrclk, CBrise, inbit, rcv_ack,
    input  sample, rcv_rdy, overrun, frame_err
  );

  modport slave (
    input  lrclk, CBrise, inbit, rcv_ack,
    output sample, rcv_rdy, overrun, frame_err
  );
endinterface

// File: rtl/i2s_recv.sv
// Serial-to-parallel I2S receiver. Deserializes left then right words
// (MSB first, one-bit delay after each lrclk edge) into {left, right},
// presents the result through a ready/ack handshake and keeps sticky
// overrun and frame-error flags. All sampling happens on CBrise cycles.
module i2s_recv #(
  parameter int DATA_BITS = 32,
  parameter int TPD       = 5
) (
  input  logic        clk,
  input  logic        rst,
  i2s_recv_if.slave   bus
);

  localparam int NB = DATA_BITS / 2;

  // Bits needed to hold value v (at least 1).
  function automatic int clogb2(input int v);
    int r;
    int x;
    r = 0;
    x = v;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  localparam int CW = clogb2(NB - 1);

  // TPD only matters to delay-annotated simulation models; the registers
  // here carry no delay, so it is just range-checked with the width.
  generate
    if ((DATA_BITS % 2) != 0 || DATA_BITS < 4 || TPD < 0) begin : g_bad_params
      $fatal(1, "i2s_recv: DATA_BITS must be even and >= 4, TPD must be >= 0");
    end
  endgenerate

  typedef enum logic [2:0] {
    SYNC  = 3'd0,
    LEFT  = 3'd1,
    LWAIT = 3'd2,
    RIGHT = 3'd3,
    RWAIT = 3'd4
  } state_t;

  state_t               state, state_n;
  logic                 primed, primed_n;
  logic                 lr_q, lr_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [NB-1:0]        left_sr, left_n;
  logic [NB-1:0]        right_sr, right_n;
  logic [DATA_BITS-1:0] sample_q, sample_n;
  logic                 rdy_q, rdy_n;
  logic                 ovr_q, ovr_n;
  logic                 ferr_q, ferr_n;

  logic                 edge_hit;
  logic                 fall;
  logic                 rise;
  logic                 shift;
  logic                 load;
  logic                 ferr_set;

  // Edge/shift qualifiers: nothing is detected until lr_q has been primed
  // by one CBrise, and the bit on an edge strobe belongs to the old word.
  always_comb begin
    edge_hit = bus.CBrise && primed && (bus.lrclk != lr_q);
    fall     = edge_hit && !bus.lrclk;
    rise     = edge_hit && bus.lrclk;
    shift    = bus.CBrise && primed && !edge_hit;
  end

  // Next-state, deserializer and handshake logic.
  always_comb begin
    state_n  = state;
    primed_n = primed;
    lr_n     = lr_q;
    cnt_n    = cnt;
    left_n   = left_sr;
    right_n  = right_sr;
    sample_n = sample_q;
    rdy_n    = rdy_q;
    ovr_n    = ovr_q;
    ferr_n   = ferr_q;
    load     = 1'b0;
    ferr_set = 1'b0;

    if (bus.CBrise) begin
      primed_n = 1'b1;
      lr_n     = bus.lrclk;
    end

    case (state)
      // A right word with no preceding left word is never assembled.
      SYNC: begin
        if (fall) begin
          state_n = LEFT;
          cnt_n   = CW'(NB - 1);
        end
      end
      LEFT: begin
        if (edge_hit) begin
          ferr_set = 1'b1;
          state_n  = SYNC;
        end else if (shift) begin
          left_n = {left_sr[NB-2:0], bus.inbit};
          if (cnt == '0) state_n = LWAIT;
          else           cnt_n   = cnt - CW'(1);
        end
      end
      LWAIT: begin
        if (rise) begin
          state_n = RIGHT;
          cnt_n   = CW'(NB - 1);
        end
      end
      RIGHT: begin
        if (edge_hit) begin
          ferr_set = 1'b1;
          state_n  = SYNC;
        end else if (shift) begin
          right_n = {right_sr[NB-2:0], bus.inbit};
          if (cnt == '0) begin
            load    = 1'b1;
            state_n = RWAIT;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
      end
      RWAIT: begin
        if (fall) begin
          state_n = LEFT;
          cnt_n   = CW'(NB - 1);
        end
      end
      default: state_n = SYNC;
    endcase

    // A completion always wins over an ack: an ack landing in the same
    // cycle only suppresses the overrun, rdy stays up for the new sample.
    if (load) begin
      sample_n = {left_sr, right_sr[NB-2:0], bus.inbit};
      rdy_n    = 1'b1;
      if (rdy_q && !bus.rcv_ack) ovr_n = 1'b1;
    end else if (rdy_q && bus.rcv_ack) begin
      rdy_n = 1'b0;
    end

    if (ferr_set) ferr_n = 1'b1;
  end

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= SYNC;
      primed   <= 1'b0;
      lr_q     <= 1'b0;
      cnt      <= '0;
      left_sr  <= '0;
      right_sr <= '0;
      sample_q <= '0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state    <= state_n;
      primed   <= primed_n;
      lr_q     <= lr_n;
      cnt      <= cnt_n;
      left_sr  <= left_n;
      right_sr <= right_n;
      sample_q <= sample_n;
      rdy_q    <= rdy_n;
      ovr_q    <= ovr_n;
      ferr_q   <= ferr_n;
    end
  end

  assign bus.sample    = sample_q;
  assign bus.rcv_rdy   = rdy_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: doc/i2s_recv.md
# i2s_recv

Serial-to-parallel I2S receiver: deserializes a two-channel I2S bit stream into one `DATA_BITS`-wide sample, left word in the upper half and right word in the lower half. It sits directly downstream of the I2S transmit stage, in the same `clk` domain, and uses the same `CBrise` bit-clock strobe and `lrclk` framing. It hands each completed sample to the consumer through a ready/acknowledge handshake and flags overruns and malformed frames.

## Interface

**Parameters**
- `DATA_BITS`, default 32: total sample width. Must be even. Each channel is `NB = DATA_BITS/2` bits.
- `TPD`, default 5: simulation-only register delay in ns.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous, active-high reset.
- `lrclk`, in, 1: left/right clock. Low = left channel, high = right channel.
- `CBrise`, in, 1: one-`clk` strobe marking a BCLK rising edge; the only sampling instant.
- `inbit`, in, 1: serial data, MSB first.
- `sample`, out, `DATA_BITS`: last completed frame, `{left, right}`.
- `rcv_rdy`, out, 1: a new sample is available.
- `rcv_ack`, in, 1: consumer has taken `sample`.
- `overrun`, out, 1: sticky; a sample was overwritten before it was acknowledged.
- `frame_err`, out, 1: sticky; an `lrclk` edge arrived before `NB` bits were collected.

## Operation

**Sampling**
- `lrclk` and `inbit` are sampled only on `clk` cycles where `CBrise`=1.
- `lr_q` holds the previous sampled `lrclk`.
- An edge is detected when the sampled `lrclk` differs from `lr_q`.
- The first `CBrise` after reset only primes `lr_q`; no edge is detected on it.

**I2S alignment**
- The bit sampled on the `CBrise` that detects an edge belongs to the previous word and is ignored.
- The next `NB` `CBrise` samples form the word: MSB on edge+1, LSB on edge+`NB`.
- Any bits after `NB` and before the next edge are ignored.

**State machine**
- `SYNC`: wait for a falling edge, then go to `LEFT`. Rising edges are ignored, so a right word with no preceding left word is discarded.
- `LEFT`: shift `NB` bits into the left register. After the `NB`th bit, go to `LWAIT`. An edge before `NB` bits: set `frame_err`, go to `SYNC`.
- `LWAIT`: wait for a rising edge, then go to `RIGHT`.
- `RIGHT`: shift `NB` bits. After the `NB`th bit, load `sample` = `{left, right}`, go to `RWAIT`. An early edge: set `frame_err`, go to `SYNC`.
- `RWAIT`: on a falling edge, go to `LEFT`.

**Bit counter**
- Loaded with `NB-1` on edge detection.
- Decremented on each `CBrise` while collecting.
- Width is `clogb2(NB-1)`.

**Handshake**
- `rcv_rdy` is set in the cycle `sample` is loaded.
- `rcv_rdy` is cleared the cycle after `rcv_ack`=1 while `rcv_rdy`=1.
- `rcv_ack` while `rcv_rdy`=0 has no effect.
- Frame completes while `rcv_rdy`=1 and `rcv_ack`=0: `sample` is overwritten, `rcv_rdy` stays 1, `overrun` is set.
- Frame completes in the same cycle as `rcv_ack`=1: the new sample loads, `rcv_rdy` stays 1, no overrun.

**Sticky flags**
- `overrun` and `frame_err` are cleared only by `rst`.

## Timing

**Reset values**
- `sample`=0, `rcv_rdy`=0, `overrun`=0, `frame_err`=0.
- State = `SYNC`, priming flag cleared, shift registers and counter = 0.

**Reset mid-operation**
- A reset during `LEFT`, `RIGHT` or a wait state discards the partial frame.
- The next output appears only after a full left+right frame that starts with a falling edge.

**Latency**
- `sample` and `rcv_rdy` update on the `clk` edge that registers the `CBrise` cycle capturing the right-channel LSB: one `clk` after that `CBrise` cycle.
- Edge detection, shifting and state transitions all complete in that same `CBrise` cycle; no extra pipeline stage.

**Input timing**
- Inputs are assumed synchronous to `clk`, produced by the same BCLK generator as `CBrise`.
- `inbit` changes only on BCLK falling strobes.

**Minimum frame**
- Each `lrclk` half-period must contain at least `NB`+1 `CBrise` strobes.

## Test plan

1. **Single frame:** `DATA_BITS`=32; left 0xA5C3, right 0x1234 in standard I2S (1-bit delay) → `sample`=0xA5C31234 and `rcv_rdy`=1 one `clk` after the right-LSB `CBrise`; `frame_err`=0, `overrun`=0.
2. **Loopback:** I2S transmit stage → `i2s_recv`, 8 random 32-bit samples, 64 BCLKs per `lrclk` period, `rcv_ack` pulsed each `rcv_rdy` → every sample received bit-exact in order; `overrun` stays 0.
3. **Overrun and simultaneous ack:** withhold `rcv_ack` across two frames → second sample visible, `overrun`=1. Then assert `rcv_ack` exactly on a completion cycle → new sample loaded, `rcv_rdy` stays 1, no further overrun.
4. **Short half-period:** left half-period of 10 `CBrise` with `NB`=16 → `frame_err`=1, no `rcv_rdy`. The next well-formed frame (left 0x0001, right 0x8000) → `sample`=0x00018000.
5. **Sync and reset:** start stimulus in the right half-period → first right word discarded. Assert `rst` mid-left-word → all outputs 0. The first valid output is the first complete frame after the next falling edge.
